sprite_engine: RTL and testbench
================================

# sprite_engine

Display-side coprocessor for the CHIP-8 core. It executes the two display instructions on a 64×32 monochrome framebuffer: DXYN (XOR-draw an N-row sprite with collision detect) and 00E0 (clear). The CPU hands off the operation with a start pulse and stalls until `done`. The block reads sprite bytes from main memory and performs read-modify-write on a separate framebuffer RAM consumed by the display scan-out.

## Interface
Parameters: none. Framebuffer geometry is fixed: 64×32 pixels, 8 bytes per row, 256 bytes.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- draw  in  1  start DXYN; sampled only in IDLE
- cls  in  1  start clear; sampled only in IDLE; wins over `draw`
- x  in  8  VX; only x[5:0] used (x mod 64)
- y  in  8  VY; only y[4:0] used (y mod 32)
- n  in  4  sprite rows, 0..15
- addr  in  12  I register, first sprite byte
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid from `done`, held until the next accepted op
- mem_addr  out  12  main-memory read address
- mem_rd_data  in  8  read data, registered, 1-cycle latency
- fb_addr  out  8  framebuffer address {row[4:0], byte[2:0]}
- fb_rd_data  in  8  framebuffer read data, 1-cycle latency
- fb_we  out  1  framebuffer write strobe
- fb_wr_data  out  8  framebuffer write data

## Operation
- Pixel order: bit 7 of a framebuffer or sprite byte is the leftmost pixel.
- On `draw`, latch the following:
  - xb = x[5:3]
  - sh = x[2:0]
  - row = y[4:0]
  - ptr = addr
  - cnt = n
- Clear `collision` when an op is accepted.
- States:
  - IDLE
  - SPR: mem_addr = ptr
  - FBL: latch sprite byte s; fb_addr = {row, xb}
  - FBR: latch L = fb_rd_data; fb_addr = {row, xb+1 mod 8}
  - WRL: latch R; write fb[{row,xb}] = L ^ (s >> sh); collision |= |(L & (s >> sh))
  - WRR: if sh ≠ 0, write fb[{row,xb+1}] = R ^ (s << (8-sh)) and OR its overlap into collision; if sh = 0, no write
  - CLR
  - DONE
- Row step, in WRR:
  - ptr += 1, wrapping mod 4096
  - row += 1, wrapping mod 32
  - cnt -= 1
  - If cnt becomes 0, go to DONE; otherwise go to SPR.
- Horizontal wrap: the right byte index wraps 7 → 0 within the same row. Pixels past x=63 appear at x=0.
- n = 0: IDLE → DONE directly. No memory or framebuffer access; collision = 0.
- `cls`: CLR writes 0x00 to fb_addr 0..255, one byte per cycle, then goes to DONE. collision = 0.
- DONE → IDLE unconditionally.
- `draw`/`cls` while busy are ignored; they are not queued.
- `fb_we` is high only in WRL, WRR with sh ≠ 0, and CLR.
- `mem_addr` and `fb_addr` hold their last value when unused.

## Timing
- Start is accepted at edge 0.
- Draw:
  - Each row takes exactly 5 cycles.
  - `done` is high in cycle 5n+1 (cycle 1 when n = 0).
  - `busy` is high in cycles 1..5n+1.
- Clear: 256 write cycles; `done` in cycle 257.
- Back-to-back: a new op is accepted in the cycle `busy` returns low, i.e. the cycle after `done`.
- Reset (rst_n low, any time, including mid-operation):
  - State returns to IDLE immediately.
  - All outputs go to 0: busy, done, collision, fb_we, fb_wr_data, fb_addr, mem_addr.
  - A partially drawn framebuffer is left as is and is not repaired.

## Structure
- Shared header `sprite_defs.vh`:
  - state encodings
  - FB_W = 64, FB_H = 32, FB_BYTES = 256
- No sub-module is required.
- The 16-bit align/XOR/collision datapath may be split out as combinational `sprite_align` (inputs s, sh, L, R; outputs new L, new R, hit).
- Memory and framebuffer RAMs are external. The CPU guarantees it does not drive main memory while `busy`.

## Test plan
- **Aligned draw:** mem[0x300]=0xF0, fb all 0, draw x=0 y=0 n=1 addr=0x300.
  - fb[0x00]=0xF0, fb[0x01] never written.
  - collision=0; `done` in cycle 6.
- **Unaligned draw:** mem[0x300]=0xFF, draw x=4 y=2 n=1.
  - fb[0x10]=0x0F, fb[0x11]=0xF0; collision=0.
- **Erase/collision:** repeat the aligned draw twice.
  - fb[0x00]=0x00, collision=1 after the second `done`.
- **Wrap:** mem[0x300..0x301]=0xFF,0xFF, draw x=124 y=63 n=2.
  - fb[0xFF]=0x0F, fb[0xF8]=0xF0, fb[0x07]=0x0F, fb[0x00]=0xF0.
  - `done` in cycle 11.
- **Clear and busy:** fb random, pulse cls, pulse draw at cycle 50.
  - All 256 bytes are 0x00; `done` only in cycle 257.
  - The draw is ignored (no extra writes); collision=0.
- **Reset mid-op:** start draw n=8, pull rst_n low in cycle 12.
  - busy, done, fb_we and collision are 0 immediately.
  - After release, a new aligned draw completes normally.

Source files
------------

// File: rtl/sprite_engine_pkg.sv
// Shared definitions for the CHIP-8 sprite engine: framebuffer geometry,
// FSM state encoding and framebuffer address packing.
package sprite_engine_pkg;

  localparam int FB_W     = 64;
  localparam int FB_H     = 32;
  localparam int FB_BYTES = 256;

  typedef logic [$clog2(FB_H)-1:0]   row_t;
  typedef logic [$clog2(FB_W/8)-1:0] col_t;

  localparam logic [7:0] CLR_LAST = 8'(FB_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPR,
    ST_FBL,
    ST_FBR,
    ST_WRL,
    ST_WRR,
    ST_CLR,
    ST_DONE
  } state_t;

  // Framebuffer byte address: row in the upper bits, byte column below.
  function automatic logic [7:0] fb_index(input row_t row, input col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/sprite_engine_align.sv
// Combinational sprite alignment: spreads an 8-bit sprite byte across two
// framebuffer bytes, XORs it in and reports per-byte pixel overlap.
module sprite_engine_align (
  input  logic [7:0] s,
  input  logic [2:0] sh,
  input  logic [7:0] l,
  input  logic [7:0] r,
  output logic [7:0] new_l,
  output logic [7:0] new_r,
  output logic       hit_l,
  output logic       hit_r
);

  logic [15:0] spread;
  logic [7:0]  ovl_l;
  logic [7:0]  ovl_r;

  // Bit 7 is the leftmost pixel, so a right shift moves pixels rightwards.
  assign spread = {s, 8'h00} >> sh;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign new_l[gi] = l[gi] ^ spread[gi+8];
      assign new_r[gi] = r[gi] ^ spread[gi];
      assign ovl_l[gi] = l[gi] & spread[gi+8];
      assign ovl_r[gi] = r[gi] & spread[gi];
    end
  endgenerate

  assign hit_l = |ovl_l;
  assign hit_r = |ovl_r;

endmodule

// File: rtl/sprite_engine.sv
// CHIP-8 display coprocessor: DXYN XOR sprite draw with collision detect and
// 00E0 framebuffer clear, via read-modify-write on an external framebuffer RAM.
module sprite_engine
  import sprite_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic        cls,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  fb_addr,
  input  logic [7:0]  fb_rd_data,
  output logic        fb_we,
  output logic [7:0]  fb_wr_data
);

  state_t      state_reg, state_next;
  col_t        xb_reg;
  logic [2:0]  sh_reg;
  row_t        row_reg;
  logic [11:0] ptr_reg;
  logic [3:0]  cnt_reg;
  logic [7:0]  s_reg, l_reg, r_reg;
  logic [7:0]  clr_idx_reg;
  logic        collision_reg;
  logic [11:0] mem_addr_hold_reg;
  logic [7:0]  fb_addr_hold_reg;

  logic [7:0]  new_l, new_r;
  logic        hit_l, hit_r;
  logic        sh_nonzero;
  col_t        xb_right;
  logic        unused_bits;

  assign sh_nonzero  = (sh_reg != 3'd0);
  assign xb_right    = xb_reg + col_t'(1);
  assign unused_bits = ^{x[7:6], y[7:5]};

  sprite_engine_align u_align (
    .s     (s_reg),
    .sh    (sh_reg),
    .l     (l_reg),
    .r     (r_reg),
    .new_l (new_l),
    .new_r (new_r),
    .hit_l (hit_l),
    .hit_r (hit_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cls) begin
          state_next = ST_CLR;
        end else if (draw) begin
          state_next = (n == 4'd0) ? ST_DONE : ST_SPR;
        end
      end
      ST_SPR:  state_next = ST_FBL;
      ST_FBL:  state_next = ST_FBR;
      ST_FBR:  state_next = ST_WRL;
      ST_WRL:  state_next = ST_WRR;
      ST_WRR:  state_next = (cnt_reg == 4'd1) ? ST_DONE : ST_SPR;
      ST_CLR:  state_next = (clr_idx_reg == CLR_LAST) ? ST_DONE : ST_CLR;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Address outputs fall back to the held value whenever a state does not use them.
  always_comb begin
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_DONE);
    fb_we      = 1'b0;
    fb_wr_data = 8'h00;
    mem_addr   = mem_addr_hold_reg;
    fb_addr    = fb_addr_hold_reg;
    case (state_reg)
      ST_SPR: mem_addr = ptr_reg;
      ST_FBL: fb_addr  = fb_index(row_reg, xb_reg);
      ST_FBR: fb_addr  = fb_index(row_reg, xb_right);
      ST_WRL: begin
        fb_addr    = fb_index(row_reg, xb_reg);
        fb_we      = 1'b1;
        fb_wr_data = new_l;
      end
      ST_WRR: begin
        if (sh_nonzero) begin
          fb_addr    = fb_index(row_reg, xb_right);
          fb_we      = 1'b1;
          fb_wr_data = new_r;
        end
      end
      ST_CLR: begin
        fb_addr = clr_idx_reg;
        fb_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xb_reg            <= '0;
      sh_reg            <= '0;
      row_reg           <= '0;
      ptr_reg           <= '0;
      cnt_reg           <= '0;
      s_reg             <= '0;
      l_reg             <= '0;
      r_reg             <= '0;
      clr_idx_reg       <= '0;
      collision_reg     <= 1'b0;
      mem_addr_hold_reg <= '0;
      fb_addr_hold_reg  <= '0;
    end else begin
      mem_addr_hold_reg <= mem_addr;
      fb_addr_hold_reg  <= fb_addr;
      case (state_reg)
        ST_IDLE: begin
          if (cls) begin
            collision_reg <= 1'b0;
            clr_idx_reg   <= '0;
          end else if (draw) begin
            collision_reg <= 1'b0;
            xb_reg        <= x[5:3];
            sh_reg        <= x[2:0];
            row_reg       <= y[4:0];
            ptr_reg       <= addr;
            cnt_reg       <= n;
          end
        end
        ST_FBL: s_reg <= mem_rd_data;
        ST_FBR: l_reg <= fb_rd_data;
        ST_WRL: begin
          r_reg         <= fb_rd_data;
          collision_reg <= collision_reg | hit_l;
        end
        ST_WRR: begin
          if (sh_nonzero) begin
            collision_reg <= collision_reg | hit_r;
          end
          ptr_reg <= ptr_reg + 12'd1;
          row_reg <= row_reg + row_t'(1);
          cnt_reg <= cnt_reg - 4'd1;
        end
        ST_CLR: clr_idx_reg <= clr_idx_reg + 8'd1;
        default: ;
      endcase
    end
  end

  assign collision = collision_reg;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: pixel-level framebuffer model,
// randomized draws/clears, per-cycle busy/done/write-strobe checks.
module tb_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw = 1'b0;
  logic        cls = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic [3:0]  n = '0;
  logic [11:0] addr = '0;
  logic        busy, done, collision, fb_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rd_data, fb_addr, fb_rd_data, fb_wr_data;

  logic [7:0]  mem [4096];
  logic [7:0]  fb  [256];
  logic        fill_go = 1'b0;

  bit          pix [32][64];
  bit          model_coll;

  int tests = 0;
  int fails = 0;

  sprite_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .draw        (draw),
    .cls         (cls),
    .x           (x),
    .y           (y),
    .n           (n),
    .addr        (addr),
    .busy        (busy),
    .done        (done),
    .collision   (collision),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .fb_addr     (fb_addr),
    .fb_rd_data  (fb_rd_data),
    .fb_we       (fb_we),
    .fb_wr_data  (fb_wr_data)
  );

  always #5 clk = ~clk;

  // External RAMs: registered reads, one-cycle latency.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    fb_rd_data  <= fb[fb_addr];
    if (fill_go) begin
      for (int i = 0; i < 256; i++) fb[i] <= 8'($urandom);
    end else if (fb_we) begin
      fb[fb_addr] <= fb_wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int idx);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[7-k] = pix[idx/8][(idx%8)*8 + k];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) pix[r][c] = 1'b0;
    model_coll = 1'b0;
  endtask

  task automatic model_draw(input int xi, input int yi, input int ni, input int ai);
    logic [7:0] b;
    int px, py;
    model_coll = 1'b0;
    for (int r = 0; r < ni; r++) begin
      b = mem[(ai + r) & 12'hFFF];
      for (int k = 0; k < 8; k++) begin
        if (b[7-k]) begin
          px = ((xi % 64) + k) % 64;
          py = ((yi % 32) + r) % 32;
          if (pix[py][px]) model_coll = 1'b1;
          pix[py][px] = ~pix[py][px];
        end
      end
    end
  endtask

  task automatic compare_fb(input string tag);
    int bad, first;
    bad = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (fb[i] !== model_byte(i)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0)
      $display("  %s: first differing fb byte 0x%02h got 0x%02h want 0x%02h",
               tag, first, fb[first], model_byte(first));
    check({tag, " fb_bytes_differing"}, bad, 0);
  endtask

  // Launch one op from a negedge, watch every cycle, then update and compare the model.
  task automatic run_op(input bit is_cls, input logic [7:0] xi, input logic [7:0] yi,
                        input logic [3:0] ni, input logic [11:0] ai,
                        input int inject_at, input string tag);
    int len, done_at, done_cnt, writes, busy_bad, exp_writes;
    len = is_cls ? 257 : 5 * int'(ni) + 1;
    exp_writes = is_cls ? 256 : int'(ni) * ((xi[2:0] != 3'd0) ? 2 : 1);
    cls = is_cls;
    draw = !is_cls;
    x = xi;
    y = yi;
    n = ni;
    addr = ai;
    @(posedge clk);
    done_at = -1;
    done_cnt = 0;
    writes = 0;
    busy_bad = 0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      cls = 1'b0;
      draw = (c == inject_at);
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (fb_we === 1'b1) writes++;
      if (c == 1 && !is_cls && ni != 4'd0) check({tag, " mem_addr_row0"}, mem_addr, ai);
    end
    draw = 1'b0;
    @(negedge clk);
    check({tag, " done_cycle"}, done_at, len);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_gaps"}, busy_bad, 0);
    check({tag, " idle_after"}, {busy, done}, 2'b00);
    check({tag, " fb_writes"}, writes, exp_writes);
    if (is_cls) model_clear();
    else model_draw(xi, yi, ni, ai);
    check({tag, " collision"}, collision, model_coll);
    compare_fb(tag);
    $display("[TB] %s: x=%0d y=%0d n=%0d addr=0x%03h done@%0d writes=%0d coll=%0b",
             tag, xi, yi, ni, ai, done_at, writes, collision);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset collision", collision, 0);
    check("reset fb_we", fb_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset fb_addr", fb_addr, 0);
    fill_go = 1'b1;
    @(negedge clk);
    fill_go = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Clear random framebuffer, draw pulse at cycle 50 must be ignored
    run_op(1'b1, 8'd0, 8'd0, 4'd5, 12'h000, 50, "clear");

    mem[12'h300] = 8'hF0;
    run_op(1'b0, 8'd0, 8'd0, 4'd1, 12'h300, 0, "aligned");
    check("aligned fb00 literal", fb[8'h00], 8'hF0);
    check("aligned fb01 literal", fb[8'h01], 8'h00);
    check("aligned coll literal", collision, 0);

    run_op(1'b0, 8'd0, 8'd0, 4'd1, 12'h300, 0, "erase");
    check("erase fb00 literal", fb[8'h00], 8'h00);
    check("erase coll literal", collision, 1);

    mem[12'h300] = 8'hFF;
    run_op(1'b0, 8'd4, 8'd2, 4'd1, 12'h300, 0, "unaligned");
    check("unaligned fb10 literal", fb[8'h10], 8'h0F);
    check("unaligned fb11 literal", fb[8'h11], 8'hF0);

    mem[12'h301] = 8'hFF;
    run_op(1'b0, 8'd124, 8'd63, 4'd2, 12'h300, 0, "wrap");
    check("wrap fbFF literal", fb[8'hFF], 8'h0F);
    check("wrap fbF8 literal", fb[8'hF8], 8'hF0);
    check("wrap fb07 literal", fb[8'h07], 8'h0F);
    check("wrap fb00 literal", fb[8'h00], 8'hF0);

    run_op(1'b0, 8'd10, 8'd10, 4'd0, 12'h123, 0, "n_zero");

    mem[12'hFFF] = 8'hA5;
    run_op(1'b0, 8'd61, 8'd30, 4'd3, 12'hFFF, 0, "ptr_wrap");

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 7) == 0)
        run_op(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 0, $sformatf("rnd%0d_cls", t));
      else
        run_op(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), 0,
               $sformatf("rnd%0d_draw", t));
    end

    // Reset mid-op: rows 0 and 1 complete by cycle 10, abort in cycle 12
    draw = 1'b1;
    x = 8'd3;
    y = 8'd0;
    n = 4'd8;
    addr = 12'h400;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      draw = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst fb_we", fb_we, 0);
    check("midrst collision", collision, 0);
    check("midrst fb_wr_data", fb_wr_data, 0);
    check("midrst fb_addr", fb_addr, 0);
    check("midrst mem_addr", mem_addr, 0);
    model_draw(3, 0, 2, 12'h400);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_fb("midrst partial");
    mem[12'h300] = 8'hF0;
    run_op(1'b0, 8'd0, 8'd5, 4'd1, 12'h300, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
